// File: rtl/leaf_stream_adapter.sv
// BFT leaf adapter: round-robin, credit-gated packing of user streams onto one link, plus per-port consumer FIFOs.
// Optional feature macro: LEAF_ADAPTER_DROP_CNT_EN builds the saturating drop counter; otherwise drop_count is 0.

module leaf_stream_adapter_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_ack,
  output logic [W-1:0] o_data,
  output logic         o_vld,
  output logic         o_drop
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [AW:0]             r_wp, r_rp;
  logic                    w_empty, w_full, w_pop, w_wr;

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_pop   = !w_empty && i_ack;
  // a pop frees the head slot this cycle, so a full FIFO can still take the push
  assign w_wr    = i_push && (!w_full || w_pop);
  assign o_drop  = i_push && w_full && !w_pop;
  assign o_vld   = !w_empty;
  assign o_data  = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wp[AW-1:0]] <= i_data;
        r_wp                <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
    end
  end
endmodule

module leaf_stream_adapter #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 4,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_IN_PORTS  = 2,
  parameter int NUM_OUT_PORTS = 2,
  parameter int FIFO_DEPTH    = 4,
  parameter int CREDIT_BITS   = 8,
  parameter int CREDIT_INIT   = 0
) (
  input  logic                                  clk,
  input  logic                                  ap_rst_n,
  input  logic [PACKET_BITS-1:0]                din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  din_leaf_user2interface,
  input  logic [NUM_IN_PORTS-1:0]               vld_user2interface,
  output logic [NUM_IN_PORTS-1:0]               ack_interface2user,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] dout_leaf_interface2user,
  output logic [NUM_OUT_PORTS-1:0]              vld_interface2user,
  input  logic [NUM_OUT_PORTS-1:0]              ack_user2interface,
  output logic [15:0]                           drop_count
);
  localparam int RW  = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int LGW = (NUM_IN_PORTS > 1) ? $clog2(NUM_IN_PORTS) : 1;
  localparam int SW  = ((CREDIT_BITS > 8) ? CREDIT_BITS : 8) + 1;
  localparam logic [NUM_PORT_BITS:0] NIN_C  = (NUM_PORT_BITS+1)'(NUM_IN_PORTS);
  localparam logic [NUM_PORT_BITS:0] NOUT_C = (NUM_PORT_BITS+1)'(NUM_OUT_PORTS);
  localparam logic [SW-1:0]          CMAX   = SW'({CREDIT_BITS{1'b1}});

  logic [PACKET_BITS-1:0]                       r_dout;
  logic [LGW-1:0]                               r_last;
  logic [NUM_IN_PORTS-1:0][RW-1:0]              r_route;
  logic [NUM_IN_PORTS-1:0][CREDIT_BITS-1:0]     r_credit;

  logic                                         w_rx_vld, w_cfg, w_idx_ok, w_bad_port, w_drop, w_found;
  logic [NUM_PORT_BITS-1:0]                     w_rx_port, w_idx;
  logic [PAYLOAD_BITS-1:0]                      w_rx_pay;
  logic [1:0]                                   w_op;
  logic [NUM_IN_PORTS-1:0]                      w_set_route, w_add, w_clr, w_elig, w_grant;
  logic [NUM_IN_PORTS-1:0][SW-1:0]              w_sum;
  logic [NUM_IN_PORTS-1:0][CREDIT_BITS-1:0]     w_credit_nxt;
  logic [NUM_IN_PORTS-1:0][PAYLOAD_BITS-1:0]    w_din;
  logic [LGW-1:0]                               w_gidx;
  logic [PACKET_BITS-1:0]                       w_tx;
  logic [NUM_OUT_PORTS-1:0]                     w_push_req, w_fifo_drop;
  logic [NUM_OUT_PORTS-1:0][PAYLOAD_BITS-1:0]   w_fifo_data;
  logic                                         w_unused;

  // receive decode; leaf field and pad bits are deliberately ignored
  assign w_rx_vld   = din_leaf_bft2interface[PACKET_BITS-1];
  assign w_rx_port  = din_leaf_bft2interface[PACKET_BITS-2-NUM_LEAF_BITS -: NUM_PORT_BITS];
  assign w_rx_pay   = din_leaf_bft2interface[PAYLOAD_BITS-1:0];
  assign w_cfg      = w_rx_vld && (w_rx_port == '0);
  assign w_op       = w_rx_pay[PAYLOAD_BITS-1 -: 2];
  assign w_idx      = w_rx_pay[PAYLOAD_BITS-3 -: NUM_PORT_BITS];
  assign w_idx_ok   = {1'b0, w_idx} < NIN_C;
  assign w_bad_port = w_rx_vld && ({1'b0, w_rx_port} > NOUT_C);
  assign w_unused   = &{1'b0, din_leaf_bft2interface, w_drop};

  always_comb begin
    w_set_route = '0;
    w_add       = '0;
    w_clr       = '0;
    w_push_req  = '0;
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      if (w_cfg && w_idx_ok && (w_idx == NUM_PORT_BITS'(i))) begin
        w_set_route[i] = (w_op == 2'b01);
        w_add[i]       = (w_op == 2'b10);
        w_clr[i]       = (w_op == 2'b11);
      end
    end
    for (int j = 0; j < NUM_OUT_PORTS; j++)
      w_push_req[j] = w_rx_vld && (w_rx_port == NUM_PORT_BITS'(j + 1));
  end

  // round-robin: first eligible above last grant, else lowest eligible at or below it
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_IN_PORTS; i++)
      w_elig[i] = vld_user2interface[i] && (r_credit[i] != '0);
    for (int i = 0; i < NUM_IN_PORTS; i++)
      if (!w_found && w_elig[i] && (i > int'(r_last))) begin
        w_found    = 1'b1;
        w_gidx     = LGW'(i);
        w_grant[i] = 1'b1;
      end
    for (int i = 0; i < NUM_IN_PORTS; i++)
      if (!w_found && w_elig[i]) begin
        w_found    = 1'b1;
        w_gidx     = LGW'(i);
        w_grant[i] = 1'b1;
      end
  end

  assign ack_interface2user = w_grant & {NUM_IN_PORTS{ap_rst_n}};
  assign w_din              = din_leaf_user2interface;

  always_comb begin
    w_tx                                = '0;
    w_tx[PACKET_BITS-1]                 = 1'b1;
    w_tx[PACKET_BITS-2 -: RW]           = r_route[w_gidx];
    w_tx[PAYLOAD_BITS-1:0]              = w_din[w_gidx];
  end

  // a grant only happens with credit != 0, so the add-and-consume sum never underflows
  always_comb begin
    w_sum        = '0;
    w_credit_nxt = '0;
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      w_sum[i] = SW'(r_credit[i]) + SW'(w_rx_pay[7:0]) - SW'(w_grant[i]);
      if (w_clr[i])
        w_credit_nxt[i] = '0;
      else if (w_add[i])
        w_credit_nxt[i] = (w_sum[i] > CMAX) ? {CREDIT_BITS{1'b1}} : w_sum[i][CREDIT_BITS-1:0];
      else
        w_credit_nxt[i] = r_credit[i] - CREDIT_BITS'(w_grant[i]);
    end
  end

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_dout   <= '0;
      r_last   <= LGW'(NUM_IN_PORTS - 1);
      r_route  <= '0;
      r_credit <= {NUM_IN_PORTS{CREDIT_BITS'(CREDIT_INIT)}};
    end else begin
      r_dout   <= w_found ? w_tx : '0;
      if (w_found) r_last <= w_gidx;
      for (int i = 0; i < NUM_IN_PORTS; i++)
        if (w_set_route[i]) r_route[i] <= w_rx_pay[RW-1:0];
      r_credit <= w_credit_nxt;
    end
  end

  assign dout_leaf_interface2bft = r_dout;

  for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_fifo
    leaf_stream_adapter_fifo #(.W(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .rst_n  (ap_rst_n),
      .i_push (w_push_req[j]),
      .i_data (w_rx_pay),
      .i_ack  (ack_user2interface[j]),
      .o_data (w_fifo_data[j]),
      .o_vld  (vld_interface2user[j]),
      .o_drop (w_fifo_drop[j])
    );
  end

  assign dout_leaf_interface2user = w_fifo_data;
  assign w_drop                   = w_bad_port | (|w_fifo_drop);

`ifdef LEAF_ADAPTER_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n)                             r_drop_cnt <= '0;
    else if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  assign drop_count = r_drop_cnt;
`else
  assign drop_count = '0;
`endif
endmodule

// File: tb/tb_leaf_stream_adapter.sv
// Directed bench for leaf_stream_adapter: credits, round-robin routing, FIFO full/drop, saturation, reset.
module tb_leaf_stream_adapter;
`ifdef LEAF_ADAPTER_DROP_CNT_EN
  localparam int DE = 1;
`else
  localparam int DE = 0;
`endif

  logic        clk = 1'b0;
  logic        ap_rst_n;
  logic [48:0] din_bft, dout_bft;
  logic [63:0] din_user, dout_user;
  logic [1:0]  vld_u, ack_i, vld_i, ack_u;
  logic [15:0] drop;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cnt;

  leaf_stream_adapter dut (
    .clk                      (clk),
    .ap_rst_n                 (ap_rst_n),
    .din_leaf_bft2interface   (din_bft),
    .dout_leaf_interface2bft  (dout_bft),
    .din_leaf_user2interface  (din_user),
    .vld_user2interface       (vld_u),
    .ack_interface2user       (ack_i),
    .dout_leaf_interface2user (dout_user),
    .vld_interface2user       (vld_i),
    .ack_user2interface       (ack_u),
    .drop_count               (drop)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [48:0] pkt(input logic [3:0] port, input logic [31:0] pay);
    return {1'b1, 4'h0, port, 8'h00, pay};
  endfunction

  function automatic logic [48:0] cfg(input logic [1:0] op, input logic [3:0] idx, input logic [7:0] n);
    return pkt(4'h0, {op, idx, 18'h0, n});
  endfunction

  function automatic logic [48:0] tx(input logic [7:0] lp, input logic [31:0] d);
    return {1'b1, lp, 8'h00, d};
  endfunction

  initial begin
    ap_rst_n = 1'b0;
    din_bft  = '0;
    din_user = '0;
    vld_u    = '0;
    ack_u    = '0;
    #12;
    chk("rst_dout", dout_bft, 0);
    chk("rst_ack", ack_i, 0);
    chk("rst_vld", vld_i, 0);
    chk("rst_drop", drop, 0);
    @(negedge clk);
    ap_rst_n = 1'b1;
    tick();

    // three credits on port 0 -> exactly three back-to-back packets
    vld_u    = 2'b01;
    din_user = {32'h0, 32'hA5A5_0000};
    din_bft  = cfg(2'b10, 4'd0, 8'd3);
    #1 chk("t1_nocredit_ack", ack_i, 0);
    tick();
    din_bft = '0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t1_ack", ack_i, (k < 3) ? 1 : 0);
      chk("t1_dout", dout_bft, (k == 0) ? 0 : tx(8'h00, 32'hA5A5_0000));
      tick();
    end
    chk("t1_dout_idle", dout_bft, 0);
    vld_u = '0;

    // fresh reset so port 0 has priority, then routes + credits, alternating output
    ap_rst_n = 1'b0;
    #1 ap_rst_n = 1'b1;
    din_bft = cfg(2'b01, 4'd0, 8'h52); tick();
    din_bft = cfg(2'b01, 4'd1, 8'h71); tick();
    din_bft = cfg(2'b10, 4'd0, 8'd4);  tick();
    din_bft = cfg(2'b10, 4'd1, 8'd4);  tick();
    din_bft  = '0;
    din_user = {32'h2222_0000, 32'h1111_0000};
    vld_u    = 2'b11;
    for (int k = 0; k < 8; k++) begin
      #1 chk("t2_ack", ack_i, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      chk("t2_dout", dout_bft, (k % 2 == 0) ? tx(8'h52, 32'h1111_0000) : tx(8'h71, 32'h2222_0000));
    end
    #1 chk("t2_ack_done", ack_i, 0);
    tick();
    chk("t2_dout_idle", dout_bft, 0);
    vld_u = '0;

    // five pushes into a depth-4 FIFO with consumer stalled
    ack_u = '0;
    for (int k = 0; k < 5; k++) begin
      din_bft = pkt(4'd1, 32'h100 + k);
      tick();
      if (k == 0) chk("t3_rx_latency", vld_i, 2'b01);
    end
    din_bft = '0;
    #1;
    chk("t3_vld", vld_i, 2'b01);
    chk("t3_head", dout_user[31:0], 32'h100);
    chk("t3_drop", drop, DE ? 1 : 0);
    ack_u = 2'b01;
    for (int k = 0; k < 4; k++) begin
      #1 chk("t3_drain", dout_user[31:0], 32'h100 + k);
      tick();
    end
    #1 chk("t3_empty", vld_i, 0);
    ack_u = '0;

    // full FIFO with simultaneous push and pop
    for (int k = 0; k < 4; k++) begin
      din_bft = pkt(4'd1, 32'h200 + k);
      tick();
    end
    din_bft = pkt(4'd1, 32'h2FF);
    ack_u   = 2'b01;
    #1 chk("t4_head", dout_user[31:0], 32'h200);
    tick();
    din_bft = '0;
    ack_u   = '0;
    #1;
    chk("t4_nodrop", drop, DE ? 1 : 0);
    ack_u = 2'b01;
    for (int k = 0; k < 4; k++) begin
      #1 chk("t4_drain", dout_user[31:0], (k < 3) ? 32'h201 + k : 32'h2FF);
      tick();
    end
    #1 chk("t4_empty", vld_i, 0);
    ack_u = '0;

    // second consumer port
    din_bft = pkt(4'd2, 32'hBEEF);
    tick();
    din_bft = '0;
    #1;
    chk("t4_p2_vld", vld_i, 2'b10);
    chk("t4_p2_data", dout_user[63:32], 32'hBEEF);
    ack_u = 2'b10;
    tick();
    ack_u = '0;
    chk("t4_p2_empty", vld_i, 0);

    // bad port drop, and an invalid packet is ignored
    din_bft = pkt(4'd15, 32'hDEAD);
    tick();
    din_bft = pkt(4'd1, 32'h55) & ~(49'h1 << 48);
    tick();
    din_bft = '0;
    #1;
    chk("t5_drop", drop, DE ? 2 : 0);
    chk("t5_vld", vld_i, 0);

    // credit 255 + add 10 with a simultaneous grant saturates at 255
    din_bft = cfg(2'b10, 4'd0, 8'hFF);
    tick();
    vld_u   = 2'b01;
    din_bft = cfg(2'b10, 4'd0, 8'd10);
    #1 chk("t6_ack", ack_i, 2'b01);
    tick();
    din_bft = '0;
    cnt = 0;
    repeat (300) begin
      if (ack_i[0]) cnt++;
      tick();
    end
    chk("t6_sat_grants", cnt, 255);
    din_bft = cfg(2'b10, 4'd0, 8'd5);
    tick();
    din_bft = cfg(2'b11, 4'd0, 8'd0);
    #1 chk("t6_clr_ack", ack_i, 2'b01);
    tick();
    din_bft = '0;
    #1;
    chk("t6_clr_dout", dout_bft, tx(8'h52, 32'h1111_0000));
    chk("t6_clr_zero", ack_i, 0);
    vld_u = '0;

    // reset pulse mid-burst
    din_bft = pkt(4'd1, 32'h77);
    tick();
    din_bft = cfg(2'b10, 4'd1, 8'd5);
    tick();
    din_bft  = '0;
    din_user = {32'h3333_0000, 32'h0};
    vld_u    = 2'b10;
    #1 chk("t7_ack", ack_i, 2'b10);
    tick();
    chk("t7_dout", dout_bft, tx(8'h71, 32'h3333_0000));
    chk("t7_vld", vld_i, 2'b01);
    #1 ap_rst_n = 1'b0;
    #1;
    chk("t7_rst_dout", dout_bft, 0);
    chk("t7_rst_ack", ack_i, 0);
    chk("t7_rst_vld", vld_i, 0);
    chk("t7_rst_drop", drop, 0);
    ap_rst_n = 1'b1;
    #1;
    chk("t7_credit_gone", ack_i, 0);
    chk("t7_fifo_gone", vld_i, 0);
    tick();
    chk("t7_dout_idle", dout_bft, 0);
    vld_u = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
